// File: rtl/rtype_ctrl_seq.sv
// rtype_ctrl_seq: control-step sequencer for register-register ALU instructions
// (fetch with memory wait states, Y/Z operand steps, LO/HI writeback, illegal trap).
module rtype_ctrl_seq #(
  parameter int NREG = 16,
  parameter int OPC_W = 5,
  parameter logic [31:0] ALU_MASK = 32'h0000_FFFC,
  parameter logic [OPC_W-1:0] OPC_MUL = OPC_W'(5'b01111),
  parameter logic [OPC_W-1:0] OPC_DIV = OPC_W'(5'b10000),
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic             mem_ready,
  input  logic [31:0]      ir,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             HIin,
  output logic             LOin,
  output logic [NREG-1:0]  Rin,
  output logic [NREG-1:0]  Rout,
  output logic [OPC_W-1:0] opcode,
  output logic             busy,
  output logic             done,
  output logic             illegal
);
  localparam int RW = $clog2(NREG);
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, ILL} state_t;
  state_t state;
  logic [OPC_W-1:0] op;
  logic [RW-1:0] ra, rb, rc;
  logic muldiv, unused_ir;
  assign op = ir[31 -: OPC_W];
  assign ra = ir[31-OPC_W -: RW];
  assign rb = ir[31-OPC_W-RW -: RW];
  assign rc = ir[31-OPC_W-2*RW -: RW];
  assign unused_ir = ^ir;
  assign muldiv = op == OPC_MUL || op == OPC_DIV;
  // Indices at or above NREG decode to no register at all.
  function automatic logic [NREG-1:0] dec(input logic [RW-1:0] i);
    for (int k = 0; k < NREG; k++) dec[k] = int'(i) == k;
  endfunction
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) state <= IDLE;
    else
      case (state)
        IDLE:    state <= start ? T0 : IDLE;
        T0:      state <= T1;
        T1:      state <= mem_ready ? T2 : T1;
        T2:      state <= ALU_MASK[op] ? T3 : ILL;
        T3:      state <= T4;
        T4:      state <= T5;
        T5:      state <= muldiv ? T6 : IDLE;
        default: state <= IDLE;
      endcase
  assign PCout    = state == T0;
  assign MARin    = state == T0;
  assign IncPC    = state == T0;
  assign PCin     = state == T0;
  assign Read     = state == T1;
  assign MDRin    = state == T1;
  assign MDRout   = state == T2;
  assign IRin     = state == T2;
  assign Yin      = state == T3;
  assign Zin      = state == T4;
  assign Zlowout  = state == T5;
  assign LOin     = state == T5 && muldiv;
  assign Zhighout = state == T6;
  assign HIin     = state == T6;
  assign Rout     = state == T3 ? dec(rb) : state == T4 ? dec(rc) : '0;
  assign Rin      = state == T5 && !muldiv ? dec(ra) & ~NREG'(ZERO_R0) : '0;
  assign opcode   = state == T4 ? op : '0;
  assign busy     = state != IDLE;
  assign done     = state == T6 || (state == T5 && !muldiv);
  assign illegal  = state == ILL;
endmodule

// File: tb/tb_rtype_ctrl_seq.sv
// tb_rtype_ctrl_seq: directed bench; per-instruction expected output trace built
// from the instruction's fields, checked against the DUT on every cycle.
module tb_rtype_ctrl_seq;
  logic Clock = 0, Resetn = 0, start = 0, mem_ready = 1;
  logic [31:0] ir = '0;
  logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin;
  logic Zlowout, Zhighout, HIin, LOin, busy, done, illegal;
  logic [15:0] Rin, Rout;
  logic [4:0] opcode;
  typedef logic [53:0] vec_t;
  vec_t q[$];
  int compared = 0, mismatched = 0, cyc = 0, last_done = -1, last_ill = -1;
  localparam logic [31:0] MASK = 32'h0000_FFFC;

  always #5 Clock = ~Clock;

  rtype_ctrl_seq dut (
    .Clock(Clock), .Resetn(Resetn), .start(start), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .Rin(Rin), .Rout(Rout), .opcode(opcode), .busy(busy), .done(done),
    .illegal(illegal)
  );

  function automatic vec_t outs();
    return {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin,
            Zlowout, Zhighout, HIin, LOin, Rin, Rout, opcode, busy, done, illegal};
  endfunction

  function automatic vec_t mk(input logic [13:0] s, input logic [15:0] rin,
                              input logic [15:0] rout, input logic [4:0] opc,
                              input logic d, input logic il);
    return {s, rin, rout, opc, 1'b1, d, il};
  endfunction

  // Expected cycle-by-cycle trace of one instruction with w memory wait cycles.
  function automatic void model(input logic [31:0] i, input int w);
    logic [4:0] op = i[31:27];
    int ra = int'(i[26:23]);
    int rb = int'(i[22:19]);
    int rc = int'(i[18:15]);
    bit md = op == 5'd15 || op == 5'd16;
    q.push_back(mk(14'h3C00, 0, 0, 0, 0, 0));
    for (int k = 0; k <= w; k++) q.push_back(mk(14'h0300, 0, 0, 0, 0, 0));
    q.push_back(mk(14'h00C0, 0, 0, 0, 0, 0));
    if (!MASK[op]) begin
      q.push_back(mk(14'h0000, 0, 0, 0, 0, 1));
      return;
    end
    q.push_back(mk(14'h0020, 0, 16'(1) << rb, 0, 0, 0));
    q.push_back(mk(14'h0010, 0, 16'(1) << rc, op, 0, 0));
    if (md) begin
      q.push_back(mk(14'h0009, 0, 0, 0, 0, 0));
      q.push_back(mk(14'h0006, 0, 0, 0, 1, 0));
    end else
      q.push_back(mk(14'h0008, ra == 0 ? 16'h0 : 16'(1) << ra, 0, 0, 1, 0));
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  always begin
    vec_t want, got;
    @(posedge Clock);
    cyc++;
    #1;
    want = (Resetn && q.size() > 0) ? q.pop_front() : '0;
    got = outs();
    if (done) last_done = cyc;
    if (illegal) last_ill = cyc;
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL outputs cycle %0d: got %h required %h", cyc, got, want);
    end
  end

  task automatic run(input logic [31:0] i, input int w, input bit hold,
                     input int abort_at, output int t0);
    int n;
    @(negedge Clock);
    ir = i;
    start = 1;
    mem_ready = 1;
    t0 = cyc;
    model(i, w);
    n = q.size();
    for (int k = 0; k < n; k++) begin
      @(negedge Clock);
      start = hold;
      mem_ready = !(k >= 1 && k <= w);
      if (k == abort_at) begin
        Resetn = 0;
        #1;
        chk("reset_outputs", longint'(outs()), 0);
        chk("reset_busy", longint'(busy), 0);
        q.delete();
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int t, t1, d0;
    repeat (2) @(negedge Clock);
    chk("reset_state", longint'(outs()), 0);
    Resetn = 1;
    model(32'h28918000, 0);
    chk("model_len", q.size(), 6);
    chk("model_t3_rout", longint'(q[3][23:8]), 16'h0004);
    chk("model_t4_rout", longint'(q[4][23:8]), 16'h0008);
    chk("model_t4_opcode", longint'(q[4][7:3]), 5);
    chk("model_t5_rin", longint'(q[5][39:24]), 16'h0002);
    chk("model_t5_done", longint'(q[5][1]), 1);
    q.delete();
    run(32'h28918000, 0, 0, -1, t);
    chk("or_done_cycle", last_done - t, 6);
    run(32'h28918000, 3, 0, -1, t);
    chk("wait_done_cycle", last_done - t, 9);
    run({5'd15, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 0, -1, t);
    chk("mul_done_cycle", last_done - t, 7);
    d0 = last_done;
    run({5'd0, 4'd1, 4'd2, 4'd2, 15'd0}, 0, 0, -1, t);
    chk("ill_cycle", last_ill - t, 4);
    chk("ill_no_done", last_done, d0);
    run({5'd31, 4'd4, 4'd5, 4'd6, 15'd0}, 2, 0, -1, t);
    chk("ill_wait_cycle", last_ill - t, 6);
    run({5'd16, 4'd2, 4'd1, 4'd1, 15'd0}, 0, 0, -1, t);
    chk("div_masked_ill", last_ill - t, 4);
    run(32'h28918000, 0, 0, 4, t);
    repeat (2) @(negedge Clock);
    start = 0;
    Resetn = 1;
    run(32'h28918000, 0, 0, -1, t);
    chk("post_reset_done", last_done - t, 6);
    run({5'd5, 4'd0, 4'd3, 4'd3, 15'd0}, 0, 1, -1, t1);
    chk("held_first_done", last_done - t1, 6);
    run({5'd5, 4'd0, 4'd3, 4'd3, 15'd0}, 0, 0, -1, t);
    chk("held_second_done", last_done - t1, 13);
    run({5'd15, 4'd0, 4'd7, 4'd7, 15'd0}, 1, 0, -1, t);
    chk("mul_wait_done", last_done - t, 8);
    repeat (3) @(negedge Clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
